// File: rtl/uart_packet_rx.sv
// Framed packet receiver sitting behind a byte-level UART receiver.
// Frame: SYNC_BYTE, four payload bytes (first byte lands in [31:24]), XOR checksum of the payload.
module uart_packet_rx #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        received,
    input  logic [7:0]  rx_byte,
    input  logic        recv_error,
    output logic        pkt_valid,
    output logic [31:0] pkt_data,
    output logic        pkt_error,
    output logic [7:0]  err_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECK
    } state_t;

    // The timeout fires on the cycle the timer would step onto TIMEOUT_CYCLES.
    localparam logic [19:0] TIMER_LAST = 20'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  acc_q, acc_d;
    logic [31:0] shreg_q, shreg_d;
    logic [19:0] timer_q, timer_d;
    logic [31:0] pkt_data_q, pkt_data_d;
    logic        pkt_valid_q, pkt_valid_d;
    logic        pkt_error_q, pkt_error_d;
    logic [7:0]  err_count_q, err_count_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        shreg_d     = shreg_q;
        timer_d     = timer_q;
        pkt_data_d  = pkt_data_q;
        pkt_valid_d = 1'b0;
        pkt_error_d = 1'b0;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                timer_d = 20'd0;
                if (received && !recv_error && (rx_byte == SYNC_BYTE)) begin
                    state_d = PAYLOAD;
                    cnt_d   = 2'd0;
                    acc_d   = 8'd0;
                end
            end

            PAYLOAD, CHECK: begin
                if (recv_error) begin
                    // A framing error wins over a simultaneous byte, which is dropped.
                    pkt_error_d = 1'b1;
                    state_d     = IDLE;
                    timer_d     = 20'd0;
                end else if (received) begin
                    timer_d = 20'd0;
                    if (state_q == PAYLOAD) begin
                        shreg_d = {shreg_q[23:0], rx_byte};
                        acc_d   = acc_q ^ rx_byte;
                        cnt_d   = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = CHECK;
                        end
                    end else begin
                        if (rx_byte == acc_q) begin
                            pkt_data_d  = shreg_q;
                            pkt_valid_d = 1'b1;
                        end else begin
                            pkt_error_d = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    pkt_error_d = 1'b1;
                    state_d     = IDLE;
                    timer_d     = 20'd0;
                end else begin
                    timer_d = timer_q + 20'd1;
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = 20'd0;
            end
        endcase

        if (pkt_error_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            acc_q       <= 8'd0;
            shreg_q     <= 32'd0;
            timer_q     <= 20'd0;
            pkt_data_q  <= 32'd0;
            pkt_valid_q <= 1'b0;
            pkt_error_q <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            shreg_q     <= shreg_d;
            timer_q     <= timer_d;
            pkt_data_q  <= pkt_data_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_error_q <= pkt_error_d;
            err_count_q <= err_count_d;
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign pkt_error = pkt_error_q;
    assign pkt_data  = pkt_data_q;
    assign err_count = err_count_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_packet_rx.sv
// Directed bench for uart_packet_rx: table of byte events with expected strobes and outputs,
// plus hand sequences for timeout, error-counter saturation and mid-frame reset.
module tb_uart_packet_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        received = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        recv_error = 1'b0;
    logic        pkt_valid;
    logic [31:0] pkt_data;
    logic        pkt_error;
    logic [7:0]  err_count;
    logic        busy;

    uart_packet_rx #(
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .received  (received),
        .rx_byte   (rx_byte),
        .recv_error(recv_error),
        .pkt_valid (pkt_valid),
        .pkt_data  (pkt_data),
        .pkt_error (pkt_error),
        .err_count (err_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // vm/em: pkt_valid/pkt_error seen on the 1st..3rd cycle after the strobe (bit 0 = first).
    typedef struct {
        string       name;
        logic        rcv;
        logic [7:0]  b;
        logic        rerr;
        logic [2:0]  vm;
        logic [2:0]  em;
        logic [31:0] data;
        logic [7:0]  ec;
        logic        busy;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(string name, logic rcv, logic [7:0] b, logic rerr,
                                logic [2:0] vm, logic [2:0] em, logic [31:0] data,
                                logic [7:0] ec, logic bz);
        vec_t v;
        v.name = name; v.rcv = rcv; v.b = b; v.rerr = rerr;
        v.vm = vm; v.em = em; v.data = data; v.ec = ec; v.busy = bz;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Entered and left on a falling edge; one byte event every 4 cycles.
    task automatic drive_event(input logic rcv, input logic [7:0] b, input logic rerr,
                               output logic [2:0] vm, output logic [2:0] em);
        vm = 3'b000;
        em = 3'b000;
        received   = rcv;
        rx_byte    = b;
        recv_error = rerr;
        @(negedge clk);
        received   = 1'b0;
        recv_error = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vm[i] = pkt_valid;
            em[i] = pkt_error;
            @(negedge clk);
        end
    endtask

    task automatic run_table();
        logic [2:0] vm, em;
        foreach (vq[i]) begin
            drive_event(vq[i].rcv, vq[i].b, vq[i].rerr, vm, em);
            n_vec++;
            if ({vm, em, pkt_data, err_count, busy} !==
                {vq[i].vm, vq[i].em, vq[i].data, vq[i].ec, vq[i].busy}) begin
                n_bad++;
                $display("FAIL vec %0d %s: got vm=%b em=%b data=%h ec=%0d busy=%b, expected vm=%b em=%b data=%h ec=%0d busy=%b",
                         i, vq[i].name, vm, em, pkt_data, err_count, busy,
                         vq[i].vm, vq[i].em, vq[i].data, vq[i].ec, vq[i].busy);
            end
        end
        vq.delete();
    endtask

    task automatic send_raw(input logic [7:0] b);
        logic [2:0] vm, em;
        drive_event(1'b1, b, 1'b0, vm, em);
    endtask

    initial begin
        int         k;
        bit         found;
        bit         wrapped;
        logic [7:0] prev_ec;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(pkt_valid), 64'd0);
        check("rst_error", 64'(pkt_error), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_errcnt", 64'(err_count), 64'd0);
        check("rst_data", 64'(pkt_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        add("good_sync", 1, 8'hA5, 0, 3'b000, 3'b000, 32'h0, 8'd0, 1);
        add("good_p0",   1, 8'h12, 0, 3'b000, 3'b000, 32'h0, 8'd0, 1);
        add("good_p1",   1, 8'h34, 0, 3'b000, 3'b000, 32'h0, 8'd0, 1);
        add("good_p2",   1, 8'h56, 0, 3'b000, 3'b000, 32'h0, 8'd0, 1);
        add("good_p3",   1, 8'h78, 0, 3'b000, 3'b000, 32'h0, 8'd0, 1);
        add("good_csum", 1, 8'h08, 0, 3'b001, 3'b000, 32'h12345678, 8'd0, 0);

        add("bad_sync",  1, 8'hA5, 0, 3'b000, 3'b000, 32'h12345678, 8'd0, 1);
        add("bad_p0",    1, 8'h12, 0, 3'b000, 3'b000, 32'h12345678, 8'd0, 1);
        add("bad_p1",    1, 8'h34, 0, 3'b000, 3'b000, 32'h12345678, 8'd0, 1);
        add("bad_p2",    1, 8'h56, 0, 3'b000, 3'b000, 32'h12345678, 8'd0, 1);
        add("bad_p3",    1, 8'h78, 0, 3'b000, 3'b000, 32'h12345678, 8'd0, 1);
        add("bad_csum",  1, 8'h09, 0, 3'b000, 3'b001, 32'h12345678, 8'd1, 0);

        add("junk_00",   1, 8'h00, 0, 3'b000, 3'b000, 32'h12345678, 8'd1, 0);
        add("junk_ff",   1, 8'hFF, 0, 3'b000, 3'b000, 32'h12345678, 8'd1, 0);
        add("junk_3c",   1, 8'h3C, 0, 3'b000, 3'b000, 32'h12345678, 8'd1, 0);
        add("a5_sync",   1, 8'hA5, 0, 3'b000, 3'b000, 32'h12345678, 8'd1, 1);
        add("a5_as_p0",  1, 8'hA5, 0, 3'b000, 3'b000, 32'h12345678, 8'd1, 1);
        add("a5_p1",     1, 8'h00, 0, 3'b000, 3'b000, 32'h12345678, 8'd1, 1);
        add("a5_p2",     1, 8'h00, 0, 3'b000, 3'b000, 32'h12345678, 8'd1, 1);
        add("a5_p3",     1, 8'h00, 0, 3'b000, 3'b000, 32'h12345678, 8'd1, 1);
        add("a5_csum",   1, 8'hA5, 0, 3'b001, 3'b000, 32'hA5000000, 8'd1, 0);

        add("rerr_sync", 1, 8'hA5, 0, 3'b000, 3'b000, 32'hA5000000, 8'd1, 1);
        add("rerr_p0",   1, 8'h12, 0, 3'b000, 3'b000, 32'hA5000000, 8'd1, 1);
        add("rerr_p1",   1, 8'h34, 0, 3'b000, 3'b000, 32'hA5000000, 8'd1, 1);
        add("rerr_hit",  0, 8'h00, 1, 3'b000, 3'b001, 32'hA5000000, 8'd2, 0);
        add("dead_sync", 1, 8'hA5, 0, 3'b000, 3'b000, 32'hA5000000, 8'd2, 1);
        add("dead_p0",   1, 8'hDE, 0, 3'b000, 3'b000, 32'hA5000000, 8'd2, 1);
        add("dead_p1",   1, 8'hAD, 0, 3'b000, 3'b000, 32'hA5000000, 8'd2, 1);
        add("dead_p2",   1, 8'hBE, 0, 3'b000, 3'b000, 32'hA5000000, 8'd2, 1);
        add("dead_p3",   1, 8'hEF, 0, 3'b000, 3'b000, 32'hA5000000, 8'd2, 1);
        add("dead_csum", 1, 8'h22, 0, 3'b001, 3'b000, 32'hDEADBEEF, 8'd2, 0);
        add("rerr_idle", 0, 8'h00, 1, 3'b000, 3'b000, 32'hDEADBEEF, 8'd2, 0);
        add("both_idle", 1, 8'hA5, 1, 3'b000, 3'b000, 32'hDEADBEEF, 8'd2, 0);
        add("both_sync", 1, 8'hA5, 0, 3'b000, 3'b000, 32'hDEADBEEF, 8'd2, 1);
        add("both_p0",   1, 8'h11, 0, 3'b000, 3'b000, 32'hDEADBEEF, 8'd2, 1);
        add("both_hit",  1, 8'h22, 1, 3'b000, 3'b001, 32'hDEADBEEF, 8'd3, 0);
        add("to_sync",   1, 8'hA5, 0, 3'b000, 3'b000, 32'hDEADBEEF, 8'd3, 1);
        add("to_p0",     1, 8'h11, 0, 3'b000, 3'b000, 32'hDEADBEEF, 8'd3, 1);
        run_table();

        // Inter-byte timeout: last strobe was sampled 4 cycles ago.
        k = 4;
        found = 1'b0;
        while (k <= 110 && !found) begin
            if (pkt_error) found = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check("timeout_seen", 64'(found), 64'd1);
        check("timeout_in_window", 64'((k >= 100) && (k <= 101)), 64'd1);
        @(negedge clk);
        check("timeout_one_cycle", 64'(pkt_error), 64'd0);
        check("timeout_idle", 64'(busy), 64'd0);
        check("timeout_errcnt", 64'(err_count), 64'd4);

        // Error-counter saturation over 300 bad frames.
        wrapped = 1'b0;
        for (int f = 0; f < 300; f++) begin
            prev_ec = err_count;
            send_raw(8'hA5);
            send_raw(8'h00);
            send_raw(8'h00);
            send_raw(8'h00);
            send_raw(8'h00);
            send_raw(8'h01);
            if (err_count < prev_ec) wrapped = 1'b1;
        end
        check("sat_errcnt", 64'(err_count), 64'd255);
        check("sat_no_wrap", 64'(wrapped), 64'd0);
        check("sat_data_kept", 64'(pkt_data), 64'hDEADBEEF);

        // Reset mid-frame.
        send_raw(8'hA5);
        send_raw(8'h12);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_errcnt", 64'(err_count), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_data", 64'(pkt_data), 64'd0);
        check("midrst_strobes", 64'({pkt_valid, pkt_error}), 64'd0);
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (pkt_error || busy) found = 1'b1;
        end
        check("post_rst_quiet", 64'(found), 64'd0);

        add("post_sync", 1, 8'hA5, 0, 3'b000, 3'b000, 32'h0, 8'd0, 1);
        add("post_p0",   1, 8'h12, 0, 3'b000, 3'b000, 32'h0, 8'd0, 1);
        add("post_p1",   1, 8'h34, 0, 3'b000, 3'b000, 32'h0, 8'd0, 1);
        add("post_p2",   1, 8'h56, 0, 3'b000, 3'b000, 32'h0, 8'd0, 1);
        add("post_p3",   1, 8'h78, 0, 3'b000, 3'b000, 32'h0, 8'd0, 1);
        add("post_csum", 1, 8'h08, 0, 3'b001, 3'b000, 32'h12345678, 8'd0, 0);
        run_table();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
